if_id_elastic_reg: RTL and testbench

Parametrised IF/ID pipeline register with a two-entry elastic (skid) buffer between fetch and decode.
- Carries PC and instruction with valid/ready handshakes on both sides.
- Stalls without combinational ready paths, supports branch/jump flush, and drives a NOP bubble when empty.
- Counts decode back-pressure cycles for performance analysis.

---
 rtl/mips_pipe_pkg.sv | 16 +
 rtl/elastic_buf2.sv | 76 +++++++
 rtl/if_id_elastic_reg.sv | 58 +++++
 tb/tb_if_id_elastic_reg.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline registers (IF/ID, ID/EX, EX/MEM).
// Contents:
//   PC_W_DEF / INSTR_W_DEF - default PC and instruction widths
//   NOP_INSTR_DEFAULT      - bubble instruction (sll $0,$0,0)
//   buf_state_e            - occupancy of a two-entry elastic buffer
package mips_pipe_pkg;
  localparam int          PC_W_DEF          = 32;
  localparam int          INSTR_W_DEF       = 32;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;
endpackage

// File: rtl/elastic_buf2.sv
// Two-entry elastic (skid) buffer with flush. The head entry lives in the main
// register and drives out_data; the skid register catches the one extra entry
// accepted while the consumer stalls. Both ready and valid are registered, so
// there is no combinational in_valid->in_ready or out_ready->out_valid path.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   flush                - drop held and incoming entries
//   in_valid/in_ready    - producer handshake, in_data payload
//   out_valid/out_ready  - consumer handshake, out_data = head payload
module elastic_buf2
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);
  buf_state_e        state, state_nx;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              push, pop;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign out_data = main_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (push) state_nx = ONE;
      ONE: begin
        if (pop && !push)      state_nx = EMPTY;
        else if (push && !pop) state_nx = TWO;
      end
      TWO:     if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
    if (flush) state_nx = EMPTY;
  end

  // ready/valid are registered copies of the next-state occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx != TWO);
      out_valid <= (state_nx != EMPTY);
      if (flush) begin
        // Zeroing main makes the visible PC read 0 after a flush.
        main_q <= '0;
        skid_q <= '0;
      end else begin
        unique case (state)
          EMPTY: if (push) main_q <= in_data;
          ONE: begin
            if (push && pop) main_q <= in_data;
            else if (push)   skid_q <= in_data;
          end
          TWO:     if (pop) main_q <= skid_q;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: rtl/if_id_elastic_reg.sv
// IF/ID pipeline register built on a two-entry elastic buffer. Adds NOP
// substitution on the instruction when empty and a saturating counter of
// decode back-pressure cycles (out_valid && !out_ready).
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid/in_ready, in_pc/in_instr    - fetch side
//   flush                         - taken branch/jump squash
//   out_valid/out_ready, out_pc/out_instr - decode side
//   stall_count                   - saturating back-pressure cycle count
module if_id_elastic_reg
  import mips_pipe_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   stall_count
);
  localparam int DATA_W = PC_W + INSTR_W;

  logic [DATA_W-1:0] head;

  elastic_buf2 #(.DATA_W(DATA_W)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({in_pc, in_instr}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head)
  );

  // PC keeps its last value when empty; only the instruction becomes a bubble.
  assign out_pc    = head[DATA_W-1 -: PC_W];
  assign out_instr = out_valid ? head[INSTR_W-1:0] : NOP_INSTR;

  // Flush does not clear the counter; a stalled flush cycle still counts.
  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= '0;
    else if (out_valid && !out_ready && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_if_id_elastic_reg.sv
module tb_if_id_elastic_reg;
  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_pc, in_instr;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_instr;
  logic [3:0]  stall_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_id_elastic_reg #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(32'h0), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .stall_count(stall_count)
  );

  // Reference: FIFO of at most two entries, registered ready/valid derived
  // from occupancy, last popped PC shown while empty.
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        q[$];
  logic [31:0] last_pc = '0;
  int          mcnt = 0;

  always @(posedge clk) begin
    bit acc, take;
    if (rst) begin
      q.delete(); last_pc = '0; mcnt = 0;
    end else begin
      if (q.size() > 0 && !out_ready && mcnt < 15) mcnt++;
      acc  = in_valid && (q.size() < 2);
      take = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete(); last_pc = '0;
      end else begin
        if (take) begin last_pc = q[0].pc; void'(q.pop_front()); end
        if (acc) q.push_back('{pc: in_pc, instr: in_instr});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ".out_pc"},    out_pc,    (q.size() > 0) ? q[0].pc : last_pc);
    chk({tag, ".out_instr"}, out_instr, (q.size() > 0) ? q[0].instr : 32'h0);
    chk({tag, ".stall"},     32'(stall_count), 32'(mcnt));
  endtask

  task automatic drive(input logic r, input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic fl, input logic ordy);
    rst = r; in_valid = iv; in_pc = pc; in_instr = ins; flush = fl; out_ready = ordy;
  endtask

  typedef struct {
    logic        r, iv;
    logic [31:0] pc, ins;
    logic        fl, ordy;
    logic        e_ir, e_ov;
    logic [31:0] e_pc, e_ins;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    //                 rst   iv    pc     instr          fl    ordy  ir    ov    pc     instr          cnt
    tbl.push_back('{1'b1,1'b1,32'h04,32'h20080005,1'b0,1'b0, 1'b1,1'b0,32'h00,32'h00000000,4'd0}); // reset
    tbl.push_back('{1'b1,1'b1,32'h04,32'h20080005,1'b0,1'b0, 1'b1,1'b0,32'h00,32'h00000000,4'd0});
    tbl.push_back('{1'b0,1'b1,32'h04,32'h20080005,1'b0,1'b1, 1'b1,1'b1,32'h04,32'h20080005,4'd0}); // stream
    tbl.push_back('{1'b0,1'b1,32'h08,32'h20090003,1'b0,1'b1, 1'b1,1'b1,32'h08,32'h20090003,4'd0});
    tbl.push_back('{1'b0,1'b1,32'h0C,32'h01095020,1'b0,1'b1, 1'b1,1'b1,32'h0C,32'h01095020,4'd0});
    tbl.push_back('{1'b0,1'b0,32'h00,32'h00000000,1'b0,1'b1, 1'b1,1'b0,32'h0C,32'h00000000,4'd0}); // pop to empty
    tbl.push_back('{1'b0,1'b1,32'h04,32'h20080005,1'b0,1'b0, 1'b1,1'b1,32'h04,32'h20080005,4'd0}); // backpressure
    tbl.push_back('{1'b0,1'b1,32'h08,32'h20090003,1'b0,1'b0, 1'b0,1'b1,32'h04,32'h20080005,4'd1});
    tbl.push_back('{1'b0,1'b1,32'h0C,32'h01095020,1'b0,1'b0, 1'b0,1'b1,32'h04,32'h20080005,4'd2});
    tbl.push_back('{1'b0,1'b1,32'h0C,32'h01095020,1'b0,1'b1, 1'b1,1'b1,32'h08,32'h20090003,4'd2});
    tbl.push_back('{1'b0,1'b1,32'h0C,32'h01095020,1'b0,1'b1, 1'b1,1'b1,32'h0C,32'h01095020,4'd2});
    tbl.push_back('{1'b0,1'b0,32'h00,32'h00000000,1'b0,1'b1, 1'b1,1'b0,32'h0C,32'h00000000,4'd2});
    tbl.push_back('{1'b0,1'b1,32'h14,32'h0000000D,1'b0,1'b0, 1'b1,1'b1,32'h14,32'h0000000D,4'd2}); // flush in TWO
    tbl.push_back('{1'b0,1'b1,32'h18,32'h0000000E,1'b0,1'b0, 1'b0,1'b1,32'h14,32'h0000000D,4'd3});
    tbl.push_back('{1'b0,1'b1,32'h10,32'h0000000F,1'b1,1'b0, 1'b1,1'b0,32'h00,32'h00000000,4'd4});
    tbl.push_back('{1'b0,1'b0,32'h00,32'h00000000,1'b0,1'b1, 1'b1,1'b0,32'h00,32'h00000000,4'd4});
    tbl.push_back('{1'b0,1'b1,32'h04,32'h20080005,1'b0,1'b0, 1'b1,1'b1,32'h04,32'h20080005,4'd4}); // push+pop in ONE
    tbl.push_back('{1'b0,1'b1,32'h08,32'h20090003,1'b0,1'b1, 1'b1,1'b1,32'h08,32'h20090003,4'd4});
    tbl.push_back('{1'b0,1'b0,32'h00,32'h00000000,1'b0,1'b1, 1'b1,1'b0,32'h08,32'h00000000,4'd4});

    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].iv, tbl[i].pc, tbl[i].ins, tbl[i].fl, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("vec%0d.in_ready", i),  32'(in_ready),    32'(tbl[i].e_ir));
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid),   32'(tbl[i].e_ov));
      chk($sformatf("vec%0d.out_pc", i),    out_pc,           tbl[i].e_pc);
      chk($sformatf("vec%0d.out_instr", i), out_instr,        tbl[i].e_ins);
      chk($sformatf("vec%0d.stall", i),     32'(stall_count), 32'(tbl[i].e_cnt));
    end

    // Saturation: one entry, then a second to reach TWO, held for 20 cycles.
    drive(0, 1, 32'h20, 32'h11, 0, 0);
    @(negedge clk);
    drive(0, 1, 32'h24, 32'h22, 0, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(0, 0, 32'h0, 32'h0, 0, 0);
    end
    chk("sat.stall",    32'(stall_count), 32'd15);
    chk("sat.in_ready", 32'(in_ready),    32'd0);
    chk("sat.out_pc",   out_pc,           32'h20);

    // Reset mid-operation from TWO, with input offered.
    drive(1, 1, 32'h28, 32'h33, 0, 0);
    @(negedge clk);
    chk("midrst.stall",     32'(stall_count), 32'd0);
    chk("midrst.in_ready",  32'(in_ready),    32'd1);
    chk("midrst.out_valid", 32'(out_valid),   32'd0);
    chk("midrst.out_pc",    out_pc,           32'h0);
    chk("midrst.out_instr", out_instr,        32'h0);
    drive(0, 1, 32'h2C, 32'h44, 0, 1);
    @(negedge clk);
    chk("postrst.out_pc", out_pc, 32'h2C);
    chk_model("postrst");

    // Randomized traffic against the queue model.
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
            $urandom & 32'hFFFF_FFFC, $urandom,
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 5));
      @(negedge clk);
      chk_model($sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
